// File: rtl/stream_downsizer.sv
// stream_downsizer: splits each wide valid/ready word into up to RATIO narrow beats, LSB slice first
module stream_downsizer #(
  parameter int IN_WIDTH = 32,
  parameter int OUT_WIDTH = 8,
  localparam int RATIO = IN_WIDTH / OUT_WIDTH,
  localparam int CW = $clog2(RATIO) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_vld,
  output logic                 s_rdy,
  input  logic [IN_WIDTH-1:0]  s_pld,
  input  logic [CW-1:0]        s_len,
  output logic                 m_vld,
  input  logic                 m_rdy,
  output logic [OUT_WIDTH-1:0] m_pld,
  output logic                 m_last,
  output logic [CW-2:0]        m_idx
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t r_state, w_next;
  logic [IN_WIDTH-1:0] r_word;
  logic [CW-2:0] r_idx;
  logic [CW-1:0] r_len, w_len;
  logic w_beat, w_done, w_take;
  assign m_vld = r_state == BUSY;
  assign m_idx = r_idx;
  assign m_pld = r_word[r_idx*OUT_WIDTH +: OUT_WIDTH];
  assign m_last = m_vld && ({1'b0, r_idx} == r_len - 1'b1);
  assign w_beat = m_vld && m_rdy;
  assign w_done = w_beat && m_last;
  assign s_rdy = !rst && (r_state == IDLE || w_done);
  assign w_take = s_vld && s_rdy;
  assign w_len = (s_len == '0 || s_len > CW'(RATIO)) ? CW'(RATIO) : s_len;
  // next state: a new word always wins, otherwise the final beat returns to idle
  always_comb begin
    w_next = w_take ? BUSY : (w_done ? IDLE : r_state);
  end
  // state, captured word and beat position
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_word <= '0;
      r_idx <= '0;
      r_len <= '0;
    end else begin
      r_state <= w_next;
      if (w_take) begin
        r_word <= s_pld;
        r_len <= w_len;
        r_idx <= '0;
      end else if (w_beat) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_stream_downsizer.sv
// tb_stream_downsizer: directed cycle-by-cycle vectors for the stream downsizer
module tb_stream_downsizer;
  logic clk = 0, rst, s_vld, s_rdy, m_vld, m_rdy, m_last;
  logic [31:0] s_pld;
  logic [2:0] s_len;
  logic [7:0] m_pld;
  logic [1:0] m_idx;
  int errs = 0, checks = 0;
  typedef struct packed {
    logic rst, vld;
    logic [31:0] pld;
    logic [2:0] len;
    logic rdy, e_srdy, e_mvld;
    logic [7:0] e_pld;
    logic e_last;
    logic [1:0] e_idx;
    logic cp;
  } vec_t;
  vec_t tbl[$];
  stream_downsizer dut (
    .clk(clk), .rst(rst), .s_vld(s_vld), .s_rdy(s_rdy), .s_pld(s_pld), .s_len(s_len),
    .m_vld(m_vld), .m_rdy(m_rdy), .m_pld(m_pld), .m_last(m_last), .m_idx(m_idx)
  );
  always #5 clk = ~clk;
  function automatic vec_t v(logic r, logic vl, logic [31:0] p, logic [2:0] l, logic rd,
                             logic es, logic em, logic [7:0] ep, logic el, logic [1:0] ei, logic c);
    v = '{r, vl, p, l, rd, es, em, ep, el, ei, c};
  endfunction
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask
  task automatic run(vec_t x, string n);
    rst = x.rst; s_vld = x.vld; s_pld = x.pld; s_len = x.len; m_rdy = x.rdy;
    @(negedge clk);
    chk({n, ".s_rdy"}, 32'(s_rdy), 32'(x.e_srdy));
    chk({n, ".m_vld"}, 32'(m_vld), 32'(x.e_mvld));
    if (x.cp) begin
      chk({n, ".m_pld"}, 32'(m_pld), 32'(x.e_pld));
      chk({n, ".m_last"}, 32'(m_last), 32'(x.e_last));
      chk({n, ".m_idx"}, 32'(m_idx), 32'(x.e_idx));
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1; s_vld = 0; s_pld = 0; s_len = 0; m_rdy = 1;
    @(posedge clk);
    #1;
    tbl.push_back(v(1, 0, 0, 0, 1, 0, 0, 8'h00, 0, 0, 1));
    tbl.push_back(v(0, 1, 32'hDDCCBBAA, 4, 1, 1, 0, 8'h00, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 1, 8'hAA, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 1, 8'hBB, 0, 1, 1));
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 1, 8'hCC, 0, 2, 1));
    tbl.push_back(v(0, 0, 0, 0, 1, 1, 1, 8'hDD, 1, 3, 1));
    tbl.push_back(v(0, 0, 0, 0, 1, 1, 0, 8'h00, 0, 0, 0));
    tbl.push_back(v(0, 1, 32'h04030201, 4, 1, 1, 0, 8'h00, 0, 0, 0));
    tbl.push_back(v(0, 1, 32'h08070605, 4, 1, 0, 1, 8'h01, 0, 0, 1));
    tbl.push_back(v(0, 1, 32'h08070605, 4, 1, 0, 1, 8'h02, 0, 1, 1));
    tbl.push_back(v(0, 1, 32'h08070605, 4, 1, 0, 1, 8'h03, 0, 2, 1));
    tbl.push_back(v(0, 1, 32'h08070605, 4, 1, 1, 1, 8'h04, 1, 3, 1));
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 1, 8'h05, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 1, 8'h06, 0, 1, 1));
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 1, 8'h07, 0, 2, 1));
    tbl.push_back(v(0, 0, 0, 0, 1, 1, 1, 8'h08, 1, 3, 1));
    tbl.push_back(v(0, 0, 0, 0, 1, 1, 0, 8'h00, 0, 0, 0));
    tbl.push_back(v(0, 1, 32'h000000EE, 1, 1, 1, 0, 8'h00, 0, 0, 0));
    tbl.push_back(v(0, 1, 32'h0000CDAB, 2, 1, 1, 1, 8'hEE, 1, 0, 1));
    tbl.push_back(v(0, 1, 32'h44332211, 0, 1, 0, 1, 8'hAB, 0, 0, 1));
    tbl.push_back(v(0, 1, 32'h44332211, 0, 1, 1, 1, 8'hCD, 1, 1, 1));
    tbl.push_back(v(0, 1, 32'h88776655, 7, 1, 0, 1, 8'h11, 0, 0, 1));
    tbl.push_back(v(0, 1, 32'h88776655, 7, 1, 0, 1, 8'h22, 0, 1, 1));
    tbl.push_back(v(0, 1, 32'h88776655, 7, 1, 0, 1, 8'h33, 0, 2, 1));
    tbl.push_back(v(0, 1, 32'h88776655, 7, 1, 1, 1, 8'h44, 1, 3, 1));
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 1, 8'h55, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 1, 8'h66, 0, 1, 1));
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 1, 8'h77, 0, 2, 1));
    tbl.push_back(v(0, 0, 0, 0, 1, 1, 1, 8'h88, 1, 3, 1));
    tbl.push_back(v(0, 0, 0, 0, 1, 1, 0, 8'h00, 0, 0, 0));
    foreach (tbl[i]) run(tbl[i], $sformatf("t%0d", i));
    run(v(0, 1, 32'h44332211, 4, 1, 1, 0, 8'h00, 0, 0, 0), "bp_take");
    run(v(0, 0, 0, 0, 1, 0, 1, 8'h11, 0, 0, 1), "bp_b0");
    for (int i = 0; i < 3; i++) run(v(0, 0, 0, 0, 0, 0, 1, 8'h22, 0, 1, 1), $sformatf("bp_hold%0d", i));
    run(v(0, 0, 0, 0, 1, 0, 1, 8'h22, 0, 1, 1), "bp_b1");
    run(v(0, 0, 0, 0, 1, 0, 1, 8'h33, 0, 2, 1), "bp_b2");
    run(v(0, 0, 0, 0, 1, 1, 1, 8'h44, 1, 3, 1), "bp_b3");
    for (int i = 0; i < 5; i++) run(v(0, 0, 0, 0, 1, 1, 0, 8'h00, 0, 0, 0), $sformatf("stall%0d", i));
    run(v(0, 1, 32'hA1B2C3D4, 4, 1, 1, 0, 8'h00, 0, 0, 0), "st_take");
    run(v(0, 0, 0, 0, 1, 0, 1, 8'hD4, 0, 0, 1), "st_b0");
    run(v(0, 0, 0, 0, 1, 0, 1, 8'hC3, 0, 1, 1), "st_b1");
    run(v(0, 0, 0, 0, 1, 0, 1, 8'hB2, 0, 2, 1), "st_b2");
    run(v(0, 0, 0, 0, 1, 1, 1, 8'hA1, 1, 3, 1), "st_b3");
    run(v(0, 1, 32'hDDCCBBAA, 4, 1, 1, 0, 8'h00, 0, 0, 0), "rs_take");
    run(v(0, 0, 0, 0, 1, 0, 1, 8'hAA, 0, 0, 1), "rs_b0");
    run(v(1, 0, 0, 0, 1, 0, 1, 8'hBB, 0, 1, 1), "rs_b1");
    run(v(0, 1, 32'h5A6B7C8D, 4, 1, 1, 0, 8'h00, 0, 0, 1), "rs_after");
    run(v(0, 0, 0, 0, 1, 0, 1, 8'h8D, 0, 0, 1), "rs_n0");
    run(v(0, 0, 0, 0, 1, 0, 1, 8'h7C, 0, 1, 1), "rs_n1");
    run(v(0, 0, 0, 0, 1, 0, 1, 8'h6B, 0, 2, 1), "rs_n2");
    run(v(0, 0, 0, 0, 1, 1, 1, 8'h5A, 1, 3, 1), "rs_n3");
    run(v(0, 0, 0, 0, 1, 1, 0, 8'h00, 0, 0, 0), "rs_idle");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
